// File: rtl/collision_lives_manager_pkg.sv
// Shared game constants and the collision/lives FSM state encoding.
// Purpose : one place for tile geometry, lane rows and state codes used by
//           the collision/lives manager and its per-car overlap checker.
// Ports   : none (package).
package collision_lives_manager_pkg;

  localparam int TILE_SIZE      = 32;   // car/frog width and height, pixels
  localparam int TILE_SHIFT     = 5;    // log2(TILE_SIZE)
  localparam int H_VISIBLE_AREA = 640;  // visible line width, pixels

  // Tile row (0-14) occupied by each car lane
  localparam int LANE_ROW_0 = 3;
  localparam int LANE_ROW_1 = 4;
  localparam int LANE_ROW_2 = 5;
  localparam int LANE_ROW_3 = 7;
  localparam int LANE_ROW_4 = 8;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HIT_FREEZE = 2'd1,
    GAME_OVER  = 2'd2
  } state_t;

endpackage

// File: rtl/collision_lives_manager_car_overlap_check.sv
// One car versus the frog: combinational row/X compare plus the stage-1
// register.
// Ports:
//   i_Clk, i_Reset  clock, synchronous active-high reset
//   i_Sample        capture enable (frame start while play is live)
//   i_Car_X         car left-edge X, pixels
//   i_Frog_X/_Y     frog left-edge X / top-edge Y, pixels
//   o_Overlap       registered overlap flag, valid the cycle after i_Sample
module car_overlap_check #(
  parameter int LANE_ROW   = 3,
  parameter int TILE_SIZE  = 32,
  parameter int TILE_SHIFT = 5
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Sample,
  input  logic [9:0] i_Car_X,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  output logic       o_Overlap
);

  localparam logic signed [10:0] TS = 11'(TILE_SIZE);

  logic [9:0]         frog_row;
  logic signed [10:0] x_diff;
  logic               row_match;
  logic               x_close;
  logic               overlap_d;
  logic               overlap_q;

  assign frog_row  = i_Frog_Y >> TILE_SHIFT;
  assign row_match = (frog_row == 10'(LANE_ROW));

  // Zero-extended 11-bit signed difference: no horizontal wrap, so a car at
  // the right edge never matches a frog at the left edge.
  assign x_diff  = $signed({1'b0, i_Frog_X}) - $signed({1'b0, i_Car_X});
  assign x_close = (x_diff < TS) && (x_diff > -TS);

  // Outside a sample cycle the stage holds nothing, so a stale compare can
  // never reach the FSM.
  always_comb begin
    overlap_d = 1'b0;
    if (i_Sample) overlap_d = row_match & x_close;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) overlap_q <= 1'b0;
    else         overlap_q <= overlap_d;
  end

  assign o_Overlap = overlap_q;

endmodule

// File: rtl/collision_lives_manager.sv
// Frog/car collision detection, lives bookkeeping and freeze/game-over
// control, evaluated once per video frame.
// Ports:
//   i_Clk, i_Reset        clock, synchronous active-high reset
//   i_Frame_Start         one-cycle pulse at start of vertical blanking
//   i_Car_X_0..4          car left-edge X positions
//   i_Frog_X, i_Frog_Y    frog position
//   i_Restart             start button, honoured only in GAME_OVER
//   o_Hit                 one-cycle pulse per accepted collision
//   o_Respawn             one-cycle pulse: frog back to start tile
//   o_Freeze              high in HIT_FREEZE and GAME_OVER
//   o_Lives               remaining lives
//   o_Game_Over           high in GAME_OVER
module collision_lives_manager #(
  parameter int TILE_SIZE     = collision_lives_manager_pkg::TILE_SIZE,
  parameter int TILE_SHIFT    = collision_lives_manager_pkg::TILE_SHIFT,
  parameter int LANE_ROW_0    = collision_lives_manager_pkg::LANE_ROW_0,
  parameter int LANE_ROW_1    = collision_lives_manager_pkg::LANE_ROW_1,
  parameter int LANE_ROW_2    = collision_lives_manager_pkg::LANE_ROW_2,
  parameter int LANE_ROW_3    = collision_lives_manager_pkg::LANE_ROW_3,
  parameter int LANE_ROW_4    = collision_lives_manager_pkg::LANE_ROW_4,
  parameter int START_LIVES   = 3,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Start,
  input  logic [9:0] i_Car_X_0,
  input  logic [9:0] i_Car_X_1,
  input  logic [9:0] i_Car_X_2,
  input  logic [9:0] i_Car_X_3,
  input  logic [9:0] i_Car_X_4,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  input  logic       i_Restart,
  output logic       o_Hit,
  output logic       o_Respawn,
  output logic       o_Freeze,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over
);

  import collision_lives_manager_pkg::*;

  localparam int NUM_CARS = 5;
  localparam int CNT_W    = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

  localparam logic [NUM_CARS-1:0][3:0] LANE_ROWS = {
    4'(LANE_ROW_4), 4'(LANE_ROW_3), 4'(LANE_ROW_2), 4'(LANE_ROW_1), 4'(LANE_ROW_0)
  };

  logic [NUM_CARS-1:0][9:0] car_x;
  logic [NUM_CARS-1:0]      overlap;
  logic                     any_hit;
  logic                     sample_en;

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       respawn_q, respawn_d;
  logic       freeze_q, freeze_d;
  logic       game_over_q, game_over_d;

  assign car_x = {i_Car_X_4, i_Car_X_3, i_Car_X_2, i_Car_X_1, i_Car_X_0};

  // Only sample while play is live and no hit is being accepted this cycle:
  // frames seen during freeze/game-over (including the respawn frame and a
  // restart frame) never produce a hit, and the pipeline is flushed on entry.
  assign sample_en = i_Frame_Start && (state_q == PLAY) && !any_hit;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    car_overlap_check #(
      .LANE_ROW   (int'(LANE_ROWS[g])),
      .TILE_SIZE  (TILE_SIZE),
      .TILE_SHIFT (TILE_SHIFT)
    ) u_car (
      .i_Clk     (i_Clk),
      .i_Reset   (i_Reset),
      .i_Sample  (sample_en),
      .i_Car_X   (car_x[g]),
      .i_Frog_X  (i_Frog_X),
      .i_Frog_Y  (i_Frog_Y),
      .o_Overlap (overlap[g])
    );
  end

  // Stage 2: several cars on the frog in one frame still count as one hit.
  assign any_hit = |overlap;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      PLAY: begin
        if (any_hit) begin
          hit_d = 1'b1;
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            cnt_d   = CNT_W'(FREEZE_FRAMES - 1);
            state_d = HIT_FREEZE;
          end
        end
      end
      HIT_FREEZE: begin
        if (i_Frame_Start) begin
          if (cnt_q == '0) begin
            respawn_d = 1'b1;
            state_d   = PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GAME_OVER: begin
        lives_d = 2'd0;
        if (i_Restart) begin
          lives_d   = 2'(START_LIVES);
          respawn_d = 1'b1;
          state_d   = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
    freeze_d    = (state_d != PLAY);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= PLAY;
      lives_q     <= 2'(START_LIVES);
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      respawn_q   <= respawn_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  assign o_Hit       = hit_q;
  assign o_Respawn   = respawn_q;
  assign o_Freeze    = freeze_q;
  assign o_Lives     = lives_q;
  assign o_Game_Over = game_over_q;

endmodule
